// File: rtl/sent_rx_frame_decoder.sv
// sent_rx_frame_decoder
// SENT fast-channel receiver front end: synchronises the raw line, measures
// falling-edge to falling-edge pulse lengths, calibrates the tick from each
// sync pulse, decodes rounded nibbles with a sequential divider, checks the
// CRC and hands whole frames over a valid/ready output register.
// Optional pause pulse after the CRC nibble: define SENT_RX_PAUSE_EN.
module sent_rx_frame_decoder #(
   parameter int NUM_DATA_NIBBLES = 6,
   parameter int CNT_W            = 16,
   parameter int CAL_TOL_SHIFT    = 6
) (
   input  logic                          clk_rx,
   input  logic                          reset_n_rx,
   input  logic                          data_pulse,
   output logic                          frame_valid,
   input  logic                          frame_ready,
   output logic [3:0]                    frame_status,
   output logic [4*NUM_DATA_NIBBLES-1:0] frame_data,
   output logic                          frame_crc_ok,
   output logic [CNT_W-1:0]              sync_cycles,
   output logic                          cal_err,
   output logic                          nibble_err,
   output logic                          overrun
);

   localparam int DW    = 4*NUM_DATA_NIBBLES;
   localparam int NUM_W = CNT_W + 7;   // P*112 + S never exceeds 128*2^CNT_W
   localparam int DEN_W = CNT_W + 1;   // 2*S
   localparam int REM_W = CNT_W + 2;   // partial remainder after one shift
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_HUNT, ST_SYNC, ST_STATUS, ST_DATA, ST_CRC
`ifdef SENT_RX_PAUSE_EN
      , ST_PAUSE
`endif
   } state_t;

   // One nibble of the table-driven CRC (x^4+x^3+x^2+1): c * x^4 mod poly.
   function automatic logic [3:0] crc_tab(input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'd0: r = 4'd0;   4'd1: r = 4'd13;  4'd2: r = 4'd7;   4'd3: r = 4'd10;
         4'd4: r = 4'd14;  4'd5: r = 4'd3;   4'd6: r = 4'd9;   4'd7: r = 4'd4;
         4'd8: r = 4'd1;   4'd9: r = 4'd12;  4'd10: r = 4'd6;  4'd11: r = 4'd11;
         4'd12: r = 4'd15; 4'd13: r = 4'd2;  4'd14: r = 4'd8;  default: r = 4'd5;
      endcase
      return r;
   endfunction

   logic             sync1_q, sync2_q, sync3_q, fall;
   logic [CNT_W-1:0] cnt_q;
   logic             cnt_sat;

   // Two-flop synchroniser plus one delay flop for falling-edge detection.
   always_ff @(posedge clk_rx or negedge reset_n_rx) begin
      if (!reset_n_rx) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= data_pulse;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign fall    = sync3_q & ~sync2_q;
   assign cnt_sat = !fall && (cnt_q == CNT_MAX - 1'b1);

   // Pulse length counter: 1 on the cycle after an edge, so at the next edge it holds P exactly.
   always_ff @(posedge clk_rx or negedge reset_n_rx) begin
      if (!reset_n_rx)             cnt_q <= '0;
      else if (fall)               cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt_q != CNT_MAX)   cnt_q <= cnt_q + 1'b1;
   end

   // ---------------- divider: T = floor((P*112 + S) / (2*S)) ----------------
   logic [CNT_W-1:0]  sync_q;
   logic [NUM_W-1:0]  num;
   logic [DEN_W-1:0]  den;
   logic              num_ovf, div_start;
   logic              div_busy_q, div_done_q, div_ovf_q;
   logic [3:0]        div_step_q;
   logic [REM_W-1:0]  rem_q, rem_shift;
   logic [DEN_W-1:0]  den_q;
   logic [9:0]        low_q, quo_q;
   logic              rem_ge;

   assign num       = NUM_W'(cnt_q) * NUM_W'(112) + NUM_W'(sync_q);
   assign den       = {sync_q, 1'b0};
   // Quotient needs more than 10 bits exactly when num/1024 >= den.
   assign num_ovf   = REM_W'(num[NUM_W-1:10]) >= REM_W'(den);
   assign rem_shift = {rem_q[REM_W-2:0], low_q[9]};
   assign rem_ge    = rem_shift >= REM_W'(den_q);

   // Restoring divider, one quotient bit per cycle, result valid 11 cycles after the start edge.
   always_ff @(posedge clk_rx or negedge reset_n_rx) begin
      if (!reset_n_rx) begin
         div_busy_q <= 1'b0;
         div_done_q <= 1'b0;
         div_ovf_q  <= 1'b0;
         div_step_q <= '0;
         rem_q      <= '0;
         den_q      <= '0;
         low_q      <= '0;
         quo_q      <= '0;
      end else begin
         div_done_q <= 1'b0;
         if (div_start) begin
            div_busy_q <= 1'b1;
            div_step_q <= '0;
            div_ovf_q  <= num_ovf;
            rem_q      <= REM_W'(num[NUM_W-1:10]);
            low_q      <= num[9:0];
            den_q      <= den;
         end else if (div_busy_q) begin
            rem_q      <= rem_ge ? rem_shift - REM_W'(den_q) : rem_shift;
            low_q      <= {low_q[8:0], 1'b0};
            quo_q      <= {quo_q[8:0], rem_ge};
            div_step_q <= div_step_q + 4'd1;
            if (div_step_q == 4'd9) begin
               div_busy_q <= 1'b0;
               div_done_q <= 1'b1;
            end
         end
      end
   end

   // ---------------- frame FSM ----------------
   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] sync_d, drift, tol;
   logic             have_sync_q, have_sync_d, bad_q, bad_d;
   logic [3:0]       status_q, status_d, crc_q, crc_d, nib_val;
   logic [DW-1:0]    data_q, data_d;
   logic             valid_q, valid_d, crc_ok_q, crc_ok_d;
   logic [3:0]       fstatus_q, fstatus_d;
   logic [DW-1:0]    fdata_q, fdata_d;
   logic             cal_err_q, cal_err_d, nib_err_q, nib_err_d, ovr_q, ovr_d;
   logic             nib_legal, frame_done, crc_match;

   assign nib_legal = !div_ovf_q && (quo_q >= 10'd12) && (quo_q <= 10'd27);
   assign nib_val   = quo_q[3:0] - 4'd12;
   assign drift     = (cnt_q > sync_q) ? cnt_q - sync_q : sync_q - cnt_q;
   assign tol       = sync_q >> CAL_TOL_SHIFT;
   assign crc_match = (nib_val == crc_tab(crc_q));

   // Next-state, nibble capture and output-register control.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sync_d      = sync_q;
      have_sync_d = have_sync_q;
      bad_d       = bad_q;
      status_d    = status_q;
      data_d      = data_q;
      crc_d       = crc_q;
      valid_d     = valid_q;
      fstatus_d   = fstatus_q;
      fdata_d     = fdata_q;
      crc_ok_d    = crc_ok_q;
      cal_err_d   = 1'b0;
      nib_err_d   = 1'b0;
      ovr_d       = 1'b0;
      div_start   = 1'b0;
      frame_done  = 1'b0;
      if (valid_q && frame_ready) valid_d = 1'b0;

      if (cnt_sat && state_q != ST_HUNT) begin
         // Line stuck: lose lock entirely and re-acquire from scratch.
         nib_err_d   = 1'b1;
         have_sync_d = 1'b0;
         state_d     = ST_HUNT;
      end else begin
         case (state_q)
            ST_HUNT: if (fall) state_d = ST_SYNC;
            ST_SYNC: if (fall) begin
               sync_d      = cnt_q;
               have_sync_d = 1'b1;
               bad_d       = 1'b0;
               if (have_sync_q && drift > tol) begin
                  cal_err_d = 1'b1;
                  bad_d     = 1'b1;
               end
               crc_d   = 4'h5;
               idx_d   = '0;
               state_d = ST_STATUS;
            end
            ST_STATUS, ST_DATA, ST_CRC: begin
               if (fall) begin
                  // A new edge before the previous nibble resolved means a runt pulse.
                  if (div_busy_q || div_done_q) begin
                     nib_err_d = 1'b1;
                     state_d   = ST_SYNC;
                  end else begin
                     div_start = 1'b1;
                  end
               end else if (div_done_q) begin
                  if (!nib_legal) begin
                     nib_err_d = 1'b1;
                     state_d   = ST_SYNC;
                  end else if (state_q == ST_STATUS) begin
                     status_d = nib_val;
                     state_d  = ST_DATA;
                  end else if (state_q == ST_DATA) begin
                     data_d = (data_q << 4) | DW'(nib_val);
                     crc_d  = crc_tab(crc_q) ^ nib_val;
                     if (idx_q == 3'(NUM_DATA_NIBBLES-1)) state_d = ST_CRC;
                     else                                 idx_d   = idx_q + 3'd1;
                  end else begin
                     frame_done = 1'b1;
`ifdef SENT_RX_PAUSE_EN
                     state_d    = ST_PAUSE;
`else
                     state_d    = ST_SYNC;
`endif
                  end
               end
            end
`ifdef SENT_RX_PAUSE_EN
            ST_PAUSE: begin
               if (fall) begin
                  if (div_busy_q || div_done_q) begin
                     nib_err_d = 1'b1;
                     state_d   = ST_SYNC;
                  end else begin
                     div_start = 1'b1;
                  end
               end else if (div_done_q) begin
                  if (div_ovf_q || quo_q < 10'd12 || quo_q > 10'd768) nib_err_d = 1'b1;
                  state_d = ST_SYNC;
               end
            end
`endif
            default: state_d = ST_HUNT;
         endcase
      end

      // A load coincident with a handshake wins; a held frame is never overwritten.
      if (frame_done && !bad_q) begin
         if (!valid_q || frame_ready) begin
            valid_d   = 1'b1;
            fstatus_d = status_q;
            fdata_d   = data_q;
            crc_ok_d  = crc_match;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // FSM, frame assembly and output registers.
   always_ff @(posedge clk_rx or negedge reset_n_rx) begin
      if (!reset_n_rx) begin
         state_q     <= ST_HUNT;
         idx_q       <= '0;
         sync_q      <= '0;
         have_sync_q <= 1'b0;
         bad_q       <= 1'b0;
         status_q    <= '0;
         data_q      <= '0;
         crc_q       <= '0;
         valid_q     <= 1'b0;
         fstatus_q   <= '0;
         fdata_q     <= '0;
         crc_ok_q    <= 1'b0;
         cal_err_q   <= 1'b0;
         nib_err_q   <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sync_q      <= sync_d;
         have_sync_q <= have_sync_d;
         bad_q       <= bad_d;
         status_q    <= status_d;
         data_q      <= data_d;
         crc_q       <= crc_d;
         valid_q     <= valid_d;
         fstatus_q   <= fstatus_d;
         fdata_q     <= fdata_d;
         crc_ok_q    <= crc_ok_d;
         cal_err_q   <= cal_err_d;
         nib_err_q   <= nib_err_d;
         ovr_q       <= ovr_d;
      end
   end

   assign frame_valid  = valid_q;
   assign frame_status = fstatus_q;
   assign frame_data   = fdata_q;
   assign frame_crc_ok = crc_ok_q;
   assign sync_cycles  = sync_q;
   assign cal_err      = cal_err_q;
   assign nibble_err   = nib_err_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_sent_rx_frame_decoder.sv
// tb_sent_rx_frame_decoder: directed frames at 8 cycles per tick (sync = 448
// cycles); one task per scenario, each with inline checks. Works with or
// without SENT_RX_PAUSE_EN (a pause pulse is inserted after every CRC then).
module tb_sent_rx_frame_decoder;
   localparam int N    = 6;
   localparam int CW   = 16;
   localparam int TICK = 8;

   logic            clk_rx = 1'b0;
   logic            reset_n_rx = 1'b0;
   logic            data_pulse = 1'b1;
   logic            frame_ready = 1'b0;
   logic            frame_valid;
   logic [3:0]      frame_status;
   logic [4*N-1:0]  frame_data;
   logic            frame_crc_ok;
   logic [CW-1:0]   sync_cycles;
   logic            cal_err, nibble_err, overrun;

   int checks = 0;
   int errors = 0;
   int n_cal = 0, n_nib = 0, n_ovr = 0, n_load = 0;
   logic [4*N-1:0] last_data = '0;
   logic valid_prev = 1'b0;
   int pause_cyc = 160;
   int s_cal, s_nib, s_ovr, s_load;

   always #5 clk_rx = ~clk_rx;

   sent_rx_frame_decoder #(.NUM_DATA_NIBBLES(N), .CNT_W(CW), .CAL_TOL_SHIFT(6)) dut (
      .clk_rx(clk_rx), .reset_n_rx(reset_n_rx), .data_pulse(data_pulse),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_status(frame_status),
      .frame_data(frame_data), .frame_crc_ok(frame_crc_ok), .sync_cycles(sync_cycles),
      .cal_err(cal_err), .nibble_err(nibble_err), .overrun(overrun)
   );

   // Event monitor: counts status pulses and frame deliveries.
   always @(negedge clk_rx) begin
      if (cal_err)    n_cal++;
      if (nibble_err) n_nib++;
      if (overrun)    n_ovr++;
      if (frame_valid && !valid_prev) begin
         n_load++;
         last_data = frame_data;
      end
      valid_prev = frame_valid;
   end

   // Polynomial multiply by x^4 modulo x^4+x^3+x^2+1, bit by bit.
   function automatic logic [3:0] mul_x4(input logic [3:0] v);
      logic [7:0] r;
      r = {v, 4'b0000};
      for (int b = 7; b >= 4; b--)
         if (r[b]) r = r ^ (8'h1D << (b - 4));
      return r[3:0];
   endfunction

   function automatic logic [3:0] model_crc(input logic [4*N-1:0] d);
      logic [3:0] c;
      c = 4'h5;
      for (int i = N - 1; i >= 0; i--) c = mul_x4(c) ^ d[4*i +: 4];
      return mul_x4(c);
   endfunction

   task automatic send_pulse(input int n);
      data_pulse = 1'b0;
      repeat (20) @(negedge clk_rx);
      data_pulse = 1'b1;
      repeat (n - 20) @(negedge clk_rx);
   endtask

   // Sync, status, data, CRC (and pause when built in). bad_idx >= 0 replaces that
   // data nibble by an 8-tick pulse and abandons the rest of the frame.
   task automatic send_frame(input int sync_len, input logic [3:0] st, input logic [4*N-1:0] d,
                             input logic [3:0] crc_xor, input int bad_idx);
      logic [3:0] c;
      send_pulse(sync_len);
      send_pulse(TICK * (12 + int'(st)));
      for (int i = 0; i < N; i++) begin
         if (i == bad_idx) begin
            send_pulse(8 * TICK);
            return;
         end
         send_pulse(TICK * (12 + int'(d[4*(N-1-i) +: 4])));
      end
      c = model_crc(d) ^ crc_xor;
      send_pulse(TICK * (12 + int'(c)));
`ifdef SENT_RX_PAUSE_EN
      send_pulse(pause_cyc);
`endif
   endtask

   task automatic send_edge();
      data_pulse = 1'b0;
      repeat (20) @(negedge clk_rx);
      data_pulse = 1'b1;
      repeat (20) @(negedge clk_rx);
   endtask

   task automatic apply_reset();
      reset_n_rx  = 1'b0;
      data_pulse  = 1'b1;
      frame_ready = 1'b0;
      repeat (5) @(negedge clk_rx);
      reset_n_rx = 1'b1;
      repeat (5) @(negedge clk_rx);
      s_cal = n_cal; s_nib = n_nib; s_ovr = n_ovr; s_load = n_load;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", frame_valid); end
      checks++; if (frame_status !== 4'h0) begin errors++; $display("FAIL rst_status got %h exp 0", frame_status); end
      checks++; if (frame_data !== 24'h0) begin errors++; $display("FAIL rst_data got %h exp 0", frame_data); end
      checks++; if (frame_crc_ok !== 1'b0) begin errors++; $display("FAIL rst_crc_ok got %b exp 0", frame_crc_ok); end
      checks++; if (sync_cycles !== 16'd0) begin errors++; $display("FAIL rst_sync got %0d exp 0", sync_cycles); end
      checks++; if ({cal_err, nibble_err, overrun} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {cal_err, nibble_err, overrun}); end
   endtask

   task automatic test_good_frame();
      apply_reset();
      send_frame(448, 4'h3, 24'h123456, 4'h0, -1);
      send_edge();
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b exp 1", frame_valid); end
      checks++; if (frame_data !== 24'h123456) begin errors++; $display("FAIL good_data got %h exp 123456", frame_data); end
      checks++; if (frame_status !== 4'h3) begin errors++; $display("FAIL good_status got %h exp 3", frame_status); end
      checks++; if (frame_crc_ok !== 1'b1) begin errors++; $display("FAIL good_crc_ok got %b exp 1", frame_crc_ok); end
      checks++; if (sync_cycles !== 16'd448) begin errors++; $display("FAIL good_sync got %0d exp 448", sync_cycles); end
      checks++; if (n_cal + n_nib + n_ovr != s_cal + s_nib + s_ovr) begin errors++; $display("FAIL good_no_err got %0d exp %0d", n_cal + n_nib + n_ovr, s_cal + s_nib + s_ovr); end
      repeat (50) @(negedge clk_rx);
      checks++; if (frame_valid !== 1'b1 || frame_data !== 24'h123456) begin errors++; $display("FAIL good_hold got %b/%h exp 1/123456", frame_valid, frame_data); end
      frame_ready = 1'b1;
      @(negedge clk_rx);
      frame_ready = 1'b0;
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_ack got %b exp 0", frame_valid); end
      $display("good_frame: data %h status %h crc_ok %b sync %0d", frame_data, frame_status, frame_crc_ok, sync_cycles);
   endtask

   task automatic test_bad_crc();
      apply_reset();
      send_frame(448, 4'h3, 24'h123456, 4'h1, -1);
      send_edge();
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL badcrc_valid got %b exp 1", frame_valid); end
      checks++; if (frame_crc_ok !== 1'b0) begin errors++; $display("FAIL badcrc_crc_ok got %b exp 0", frame_crc_ok); end
      checks++; if (frame_data !== 24'h123456) begin errors++; $display("FAIL badcrc_data got %h exp 123456", frame_data); end
      $display("bad_crc: valid %b crc_ok %b data %h", frame_valid, frame_crc_ok, frame_data);
   endtask

   task automatic test_cal_drift();
      apply_reset();
      frame_ready = 1'b1;
      send_frame(448, 4'h3, 24'h123456, 4'h0, -1);
      send_frame(460, 4'h3, 24'h123456, 4'h0, -1);
      send_edge();
      frame_ready = 1'b0;
      checks++; if (n_cal - s_cal != 1) begin errors++; $display("FAIL cal_pulses got %0d exp 1", n_cal - s_cal); end
      checks++; if (n_load - s_load != 1) begin errors++; $display("FAIL cal_loads got %0d exp 1", n_load - s_load); end
      checks++; if (sync_cycles !== 16'd460) begin errors++; $display("FAIL cal_sync got %0d exp 460", sync_cycles); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL cal_valid got %b exp 0", frame_valid); end
      $display("cal_drift: cal_err pulses %0d loads %0d sync %0d", n_cal - s_cal, n_load - s_load, sync_cycles);
   endtask

   task automatic test_nibble_err();
      apply_reset();
      send_frame(448, 4'h3, 24'h123456, 4'h0, 2);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL nib_dropped got %b exp 0", frame_valid); end
      send_frame(448, 4'h5, 24'h9A0F17, 4'h0, -1);
      send_edge();
      checks++; if (n_nib - s_nib != 1) begin errors++; $display("FAIL nib_pulses got %0d exp 1", n_nib - s_nib); end
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL nib_next_valid got %b exp 1", frame_valid); end
      checks++; if (frame_data !== 24'h9A0F17) begin errors++; $display("FAIL nib_next_data got %h exp 9a0f17", frame_data); end
      checks++; if (frame_status !== 4'h5) begin errors++; $display("FAIL nib_next_status got %h exp 5", frame_status); end
      checks++; if (n_cal != s_cal) begin errors++; $display("FAIL nib_no_cal got %0d exp 0", n_cal - s_cal); end
      $display("nibble_err: pulses %0d next data %h", n_nib - s_nib, frame_data);
   endtask

   task automatic test_overrun();
      apply_reset();
      send_frame(448, 4'h3, 24'h123456, 4'h0, -1);
      send_frame(448, 4'h4, 24'h654321, 4'h0, -1);
      send_edge();
      checks++; if (n_ovr - s_ovr != 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", n_ovr - s_ovr); end
      checks++; if (n_load - s_load != 1) begin errors++; $display("FAIL ovr_loads got %0d exp 1", n_load - s_load); end
      checks++; if (frame_data !== 24'h123456) begin errors++; $display("FAIL ovr_data got %h exp 123456", frame_data); end
      checks++; if (frame_status !== 4'h3) begin errors++; $display("FAIL ovr_status got %h exp 3", frame_status); end
      frame_ready = 1'b1;
      @(negedge clk_rx);
      frame_ready = 1'b0;
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack got %b exp 0", frame_valid); end
      $display("overrun: pulses %0d held data %h", n_ovr - s_ovr, frame_data);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      frame_ready = 1'b1;
      send_frame(448, 4'h1, 24'h111111, 4'h0, -1);
      send_frame(448, 4'h2, 24'hFEDCBA, 4'h0, -1);
      send_frame(448, 4'h0, 24'h0F0F0F, 4'h0, -1);
      send_edge();
      frame_ready = 1'b0;
      checks++; if (n_load - s_load != 3) begin errors++; $display("FAIL b2b_loads got %0d exp 3", n_load - s_load); end
      checks++; if (n_ovr != s_ovr) begin errors++; $display("FAIL b2b_overrun got %0d exp 0", n_ovr - s_ovr); end
      checks++; if (last_data !== 24'h0F0F0F) begin errors++; $display("FAIL b2b_last_data got %h exp 0f0f0f", last_data); end
      $display("back_to_back: loads %0d last data %h", n_load - s_load, last_data);
   endtask

`ifdef SENT_RX_PAUSE_EN
   task automatic test_pause();
      apply_reset();
      frame_ready = 1'b1;
      pause_cyc = 300 * TICK;
      send_frame(448, 4'h3, 24'h123456, 4'h0, -1);
      send_frame(448, 4'h3, 24'hABCDEF, 4'h0, -1);
      send_edge();
      frame_ready = 1'b0;
      pause_cyc = 160;
      checks++; if (n_load - s_load != 2) begin errors++; $display("FAIL pause_loads got %0d exp 2", n_load - s_load); end
      checks++; if (n_nib != s_nib) begin errors++; $display("FAIL pause_nib got %0d exp 0", n_nib - s_nib); end
      checks++; if (last_data !== 24'hABCDEF) begin errors++; $display("FAIL pause_data got %h exp abcdef", last_data); end
      $display("pause: loads %0d last data %h", n_load - s_load, last_data);
   endtask
`endif

   task automatic test_reset_mid_frame();
      apply_reset();
      send_frame(448, 4'h3, 24'h123456, 4'h0, -1);
      send_pulse(448);
      send_pulse(TICK * 15);
      data_pulse = 1'b0;
      repeat (7) @(negedge clk_rx);
      #3 reset_n_rx = 1'b0;
      #1;
      checks++; if (frame_valid !== 1'b0 || frame_data !== 24'h0 || frame_status !== 4'h0) begin errors++; $display("FAIL mid_rst_frame got %b/%h/%h exp 0/0/0", frame_valid, frame_data, frame_status); end
      checks++; if (sync_cycles !== 16'd0 || frame_crc_ok !== 1'b0) begin errors++; $display("FAIL mid_rst_misc got %0d/%b exp 0/0", sync_cycles, frame_crc_ok); end
      repeat (3) @(negedge clk_rx);
      data_pulse = 1'b1;
      repeat (3) @(negedge clk_rx);
      reset_n_rx = 1'b1;
      repeat (5) @(negedge clk_rx);
      s_cal = n_cal;
      send_frame(448, 4'h6, 24'h2468AC, 4'h0, -1);
      send_edge();
      checks++; if (frame_valid !== 1'b1 || frame_data !== 24'h2468AC) begin errors++; $display("FAIL mid_rst_resync got %b/%h exp 1/2468ac", frame_valid, frame_data); end
      checks++; if (n_cal != s_cal) begin errors++; $display("FAIL mid_rst_cal got %0d exp 0", n_cal - s_cal); end
      $display("reset_mid_frame: resync data %h valid %b", frame_data, frame_valid);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_crc();
      test_cal_drift();
      test_nibble_err();
      test_overrun();
      test_back_to_back();
`ifdef SENT_RX_PAUSE_EN
      test_pause();
`endif
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
